// File: rtl/decoder_if.sv
// Bus between instruction fetch and the TD4 instruction decoder.
// The fetch side drives the opcode nibble and carry flag; the decoder
// returns the registered ALU select, load enables and illegal flag.
// There is no handshake: the decoder samples op/carry_flag on every
// rising clock edge, and its outputs are valid one edge later.
interface decoder_if;
   logic [3:0] op;
   logic       carry_flag;
   logic [1:0] sel;
   logic [3:0] load;
   logic       illegal;

   modport master (
      output op,
      output carry_flag,
      input  sel,
      input  load,
      input  illegal
   );

   modport slave (
      input  op,
      input  carry_flag,
      output sel,
      output load,
      output illegal
   );
endinterface

// File: rtl/decoder.sv
// TD4 instruction decoder: opcode nibble + carry flag -> ALU operand
// select and one-hot register load enables, registered for one cycle of
// latency so the enables seen by the register file are glitch-free.
module decoder (
   input logic       clk,
   input logic       rst_n,
   decoder_if.slave  bus
);

   // ALU operand select encodings
   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_IN   = 2'b10;
   localparam logic [1:0] SEL_ZERO = 2'b11;

   // Load enable bits
   localparam logic [3:0] LD_NONE = 4'b0000;
   localparam logic [3:0] LD_A    = 4'b0001;
   localparam logic [3:0] LD_B    = 4'b0010;
   localparam logic [3:0] LD_OUT  = 4'b0100;
   localparam logic [3:0] LD_PC   = 4'b1000;

   logic [1:0] sel_d;
   logic [3:0] load_d;
   logic       illegal_d;

   // Combinational decode; undefined opcodes fall through to the NOP default
   always_comb begin
      sel_d     = SEL_ZERO;
      load_d    = LD_NONE;
      illegal_d = 1'b0;
      case (bus.op)
         4'b0000: begin sel_d = SEL_A;    load_d = LD_A;   end // ADD A,Im
         4'b0001: begin sel_d = SEL_B;    load_d = LD_A;   end // MOV A,B
         4'b0010: begin sel_d = SEL_IN;   load_d = LD_A;   end // IN A
         4'b0011: begin sel_d = SEL_ZERO; load_d = LD_A;   end // MOV A,Im
         4'b0100: begin sel_d = SEL_A;    load_d = LD_B;   end // MOV B,A
         4'b0101: begin sel_d = SEL_B;    load_d = LD_B;   end // ADD B,Im
         4'b0110: begin sel_d = SEL_IN;   load_d = LD_B;   end // IN B
         4'b0111: begin sel_d = SEL_ZERO; load_d = LD_B;   end // MOV B,Im
         4'b1001: begin sel_d = SEL_B;    load_d = LD_OUT; end // OUT B
         4'b1011: begin sel_d = SEL_ZERO; load_d = LD_OUT; end // OUT Im
         4'b1110: begin                                        // JNC Im
            sel_d  = SEL_ZERO;
            load_d = bus.carry_flag ? LD_NONE : LD_PC;
         end
         4'b1111: begin sel_d = SEL_ZERO; load_d = LD_PC;  end // JMP Im
         default: begin                                        // undefined: NOP
            sel_d     = SEL_ZERO;
            load_d    = LD_NONE;
            illegal_d = 1'b1;
         end
      endcase
   end

   // Output registers; reset parks the ALU on zero with every load disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sel     <= SEL_ZERO;
         bus.load    <= LD_NONE;
         bus.illegal <= 1'b0;
      end else begin
         bus.sel     <= sel_d;
         bus.load    <= load_d;
         bus.illegal <= illegal_d;
      end
   end

endmodule

// File: tb/tb_decoder.sv
// Testbench for the TD4 instruction decoder: table-driven reference model
// with an expected queue checked on every falling edge, plus literal
// spot checks for reset, JNC/JMP, illegal opcodes and latency.
module tb_decoder;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decoder_if bus ();

   decoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- reference model ----------------
   // Packed result layout: {illegal, sel[1:0], load[3:0]}
   localparam logic [6:0] RST_VAL = 7'b0_11_0000;

   logic [1:0] sel_tab  [16] = '{2'b00, 2'b01, 2'b10, 2'b11,
                                 2'b00, 2'b01, 2'b10, 2'b11,
                                 2'b11, 2'b01, 2'b11, 2'b11,
                                 2'b11, 2'b11, 2'b11, 2'b11};
   logic [3:0] load_tab [16] = '{4'd1, 4'd1, 4'd1, 4'd1,
                                 4'd2, 4'd2, 4'd2, 4'd2,
                                 4'd0, 4'd4, 4'd0, 4'd4,
                                 4'd0, 4'd0, 4'd8, 4'd8};
   logic       ill_tab  [16] = '{1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b1, 1'b0,
                                 1'b1, 1'b1, 1'b0, 1'b0};

   function automatic logic [6:0] model(input logic [3:0] op, input logic c);
      logic [3:0] ld;
      ld = load_tab[op];
      if (op == 4'd14 && c) ld = 4'd0; // JNC not taken
      return {ill_tab[op], sel_tab[op], ld};
   endfunction

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [6:0] exp_q[$];
   logic [6:0] cur_exp = RST_VAL;

   task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got ill/sel/load=%b/%b/%b required %b/%b/%b",
                  name, $time, got[6], got[5:4], got[3:0], exp[6], exp[5:4], exp[3:0]);
      end
   endtask

   function automatic logic [6:0] dut_out();
      return {bus.illegal, bus.sel, bus.load};
   endfunction

   // Predict the registered outputs from what is presented at each edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         cur_exp = RST_VAL;
      end else begin
         exp_q.push_back(model(bus.op, bus.carry_flag));
      end
   end

   // Compare on every falling edge, away from the sampling edge
   always @(negedge clk) begin
      if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
      chk("cycle", dut_out(), cur_exp);
   end

   // ---------------- driver ----------------
   task automatic step(input logic [3:0] op, input logic c);
      @(negedge clk);
      #1;
      bus.op         = op;
      bus.carry_flag = c;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] ill_ops [4] = '{4'b1000, 4'b1010, 4'b1100, 4'b1101};

   initial begin
      bus.op         = 4'b0000;
      bus.carry_flag = 1'b0;

      // Reset held
      repeat (3) @(negedge clk);
      #1;
      chk("reset_hold", dut_out(), RST_VAL);
      rst_n = 1'b1;

      // Opcode sweep with carry clear
      for (int i = 0; i < 16; i++) begin
         step(4'(i), 1'b0);
         if (i == 2)  chk("op0010", dut_out(), 7'b0_10_0001);
         if (i == 9)  chk("op1001", dut_out(), 7'b0_01_0100);
         if (i == 14) chk("op1110", dut_out(), 7'b0_11_1000);
      end

      // JNC carry dependence
      step(4'b1110, 1'b1);
      chk("jnc_c1", dut_out(), 7'b0_11_0000);
      step(4'b1110, 1'b0);
      chk("jnc_c0", dut_out(), 7'b0_11_1000);

      // JMP ignores carry
      step(4'b1111, 1'b0);
      chk("jmp_c0", dut_out(), 7'b0_11_1000);
      step(4'b1111, 1'b1);
      chk("jmp_c1", dut_out(), 7'b0_11_1000);

      // Illegal opcodes, then a defined one
      for (int i = 0; i < 4; i++) begin
         step(ill_ops[i], i[0]);
         chk("illegal", dut_out(), 7'b1_11_0000);
      end
      step(4'b0000, 1'b0);
      chk("after_illegal", dut_out(), 7'b0_00_0001);

      // Latency: mid-cycle op change must not reach the outputs early
      step(4'b0010, 1'b0);
      #2 bus.op = 4'b1001;
      #1 chk("latency_hold", dut_out(), 7'b0_10_0001);
      @(posedge clk);
      #1 chk("latency_update", dut_out(), 7'b0_01_0100);

      // Asynchronous reset mid-run
      step(4'b0101, 1'b0);
      chk("pre_reset", dut_out(), 7'b0_01_0010);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", dut_out(), RST_VAL);
      @(negedge clk);
      #1 rst_n = 1'b1;
      #1 chk("reset_release", dut_out(), RST_VAL);

      // Random stimulus checked by the per-cycle compare
      for (int i = 0; i < 300; i++) begin
         step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Instruction decoder for the 4-bit TD4-style CPU.
- Decodes the 4-bit opcode (upper nibble of the instruction) and the carry flag into two signals:
  - ALU input-mux select (sel)
  - per-register load enables (load)
- Sits between instruction fetch and the register file/ALU.
- Outputs are registered: one cycle of latency, clean glitch-free enables.

Parameters:
- None.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- op  input  4  opcode nibble of the current instruction
- carry_flag  input  1  carry flag from the previous ALU operation (1 = carry set)
- sel  output  2  ALU operand select: 00 = reg A, 01 = reg B, 10 = input port, 11 = zero
- load  output  4  active-high load enables: bit0 = A, bit1 = B, bit2 = OUT, bit3 = PC
- illegal  output  1  high when the registered opcode is undefined

Behaviour:
- Reset: rst_n low asynchronously forces sel = 2'b11, load = 4'b0000, illegal = 0. Outputs hold these values while rst_n is low.
- Release: the first decode happens on the first rising clk edge with rst_n high.
- Latency: op and carry_flag are sampled on the rising clk edge; decoded values appear on sel/load/illegal after that edge and are held until the next edge.
- Purely combinational decode feeds the output registers. No other state.
- Decode table (op -> sel, load):
  - 0000 ADD A,Im -> 00, 0001
  - 0001 MOV A,B -> 01, 0001
  - 0010 IN A -> 10, 0001
  - 0011 MOV A,Im -> 11, 0001
  - 0100 MOV B,A -> 00, 0010
  - 0101 ADD B,Im -> 01, 0010
  - 0110 IN B -> 10, 0010
  - 0111 MOV B,Im -> 11, 0010
  - 1001 OUT B -> 01, 0100
  - 1011 OUT Im -> 11, 0100
  - 1110 JNC Im -> 11, 1000 if carry_flag = 0; 11, 0000 if carry_flag = 1
  - 1111 JMP Im -> 11, 1000 (carry_flag ignored)
- Undefined opcodes 1000, 1010, 1100, 1101:
  - Execute as NOP: sel = 11, load = 0000, illegal = 1.
  - illegal = 0 for every defined opcode.
- carry_flag only affects opcode 1110.
- Exactly one load bit is high for every defined opcode except JNC with carry set.
- load is never wider than one-hot.
- Boundary cases:
  - op wrapping 1111 -> 0000 needs no special handling.
  - Reset asserted mid-operation clears outputs immediately, without waiting for a clock edge.
  - X/unknown op values are not required to be handled.

Test Plan:
- Reset: hold rst_n = 0 with op = 0000 -> sel = 11, load = 0000, illegal = 0. Assert rst_n low mid-run -> same values immediately, before the next clk edge.
- Opcode sweep with carry_flag = 0: step op 0000..1111, one per clock -> each sel/load matches the table one cycle later. Spot checks:
  - op 0010 -> 10/0001
  - op 1001 -> 01/0100
  - op 1110 -> 11/1000
- JNC carry dependence: op = 1110, carry_flag = 1 -> sel = 11, load = 0000. Toggle carry_flag to 0 -> load = 1000 after the next edge.
- JMP ignores carry: op = 1111 with carry_flag = 0 and with carry_flag = 1 -> sel = 11, load = 1000 both times.
- Illegal opcodes: op = 1000, 1010, 1100, 1101 -> sel = 11, load = 0000, illegal = 1. The next defined opcode (e.g. 0000) -> illegal = 0, load = 0001.
- Latency check: change op between clock edges -> outputs stay unchanged until the next rising edge.
